bf_add_sub_pipe: RTL and testbench



---
 rtl/bf_pkg.sv | 23 ++
 rtl/bf_lzc.sv | 14 +
 rtl/bf_add_sub_pipe.sv | 192 +++++++++++++++++++
 tb/tb_bf_add_sub_pipe.sv | 137 +++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// bf_pkg: shared types, defaults and rounding helper for the bf_add_sub_pipe adder.
//   Defaults describe bfloat16 (8-bit exponent, 7-bit fraction, 3 guard/round/sticky bits).
package bf_pkg;
    localparam int BF_EXP_W = 8;
    localparam int BF_MAN_W = 7;
    localparam int BF_GRS_W = 3;
    localparam int BF_W     = 1 + BF_EXP_W + BF_MAN_W;
    localparam int BF_SIG_W = BF_MAN_W + BF_GRS_W + 2;

    typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} bf_class_e;

    typedef struct packed {
        logic                sign;
        logic [BF_EXP_W-1:0] exp;
        logic [BF_MAN_W:0]   sig;
    } bf_unpacked_t;

    localparam logic [BF_W-1:0] BF_QNAN = {1'b0, {BF_EXP_W{1'b1}}, 1'b1, {(BF_MAN_W-1){1'b0}}};

    function automatic logic rne_inc(input logic lsb, input logic g, input logic r, input logic s);
        return g & (r | s | lsb);
    endfunction
endpackage

// File: rtl/bf_lzc.sv
// bf_lzc: leading-zero counter; cnt_o = WIDTH when vec_i is all zeros.
//   Ports: vec_i (WIDTH), cnt_o ($clog2(WIDTH+1)).
module bf_lzc #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0]           vec_i,
    output logic [$clog2(WIDTH+1)-1:0] cnt_o
);
    always_comb begin
        cnt_o = ($clog2(WIDTH+1))'(WIDTH);
        for (int i = 0; i < WIDTH; i++)
            if (vec_i[i]) cnt_o = ($clog2(WIDTH+1))'(WIDTH - 1 - i);
    end
endmodule

// File: rtl/bf_add_sub_pipe.sv
// bf_add_sub_pipe: 3-stage pipelined float add/sub (flush-to-zero, RNE) with valid/ready.
//   Ports: clk, rst_n (sync, active-low); in_valid/in_ready, a, b, cntl (0 = a+b, 1 = a-b);
//          out_valid/out_ready, c, flag_invalid (NaN result), flag_overflow (finite -> inf).
//   Optional STICKY_FLAGS_EN: adds flag_clr, sticky_invalid, sticky_overflow.
module bf_add_sub_pipe
    import bf_pkg::*;
#(
    parameter int EXP_W = BF_EXP_W,
    parameter int MAN_W = BF_MAN_W,
    parameter int GRS_W = BF_GRS_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 cntl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] c,
    output logic                 flag_invalid,
    output logic                 flag_overflow
`ifdef STICKY_FLAGS_EN
    ,
    input  logic                 flag_clr,
    output logic                 sticky_invalid,
    output logic                 sticky_overflow
`endif
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int SW   = MAN_W + GRS_W + 2;
    localparam int LZ_W = $clog2(SW + 1);
    localparam logic [W-1:0]     QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [EXP_W+1:0] EMAX = {2'b00, {EXP_W{1'b1}}};

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   sig;
    } unp_t;

    function automatic bf_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        return (e == '0) ? CLS_ZERO : (&e) ? ((f == '0) ? CLS_INF : CLS_NAN) : CLS_NORM;
    endfunction

    logic adv;
    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    unp_t           ua, ub, ul, us;
    bf_class_e      ca, cb;
    logic           a_ge_b, byp1_d, inv1_d;
    logic [W-1:0]   bval1_d;
    logic           v1_q, byp1_q, inv1_q, sign1_q, sub1_q;
    logic [W-1:0]   bval1_q;
    logic [EXP_W-1:0] exp1_q, d1_q;
    logic [MAN_W:0] sigl1_q, sigs1_q;

    // Specials are resolved here so S2/S3 only ever see two normal operands.
    always_comb begin
        ua      = '{a[W-1], a[W-2:MAN_W], {1'b1, a[MAN_W-1:0]}};
        ub      = '{b[W-1] ^ cntl, b[W-2:MAN_W], {1'b1, b[MAN_W-1:0]}};
        ca      = classify(ua.exp, a[MAN_W-1:0]);
        cb      = classify(ub.exp, b[MAN_W-1:0]);
        a_ge_b  = {ua.exp, ua.sig} >= {ub.exp, ub.sig};
        ul      = a_ge_b ? ua : ub;
        us      = a_ge_b ? ub : ua;
        inv1_d  = ca == CLS_NAN || cb == CLS_NAN ||
                  (ca == CLS_INF && cb == CLS_INF && ua.sign != ub.sign);
        byp1_d  = inv1_d || ca != CLS_NORM || cb != CLS_NORM;
        bval1_d = inv1_d                           ? QNAN :
                  ca == CLS_INF                    ? {ua.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                  cb == CLS_INF                    ? {ub.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                  ca == CLS_ZERO && cb == CLS_ZERO ? {ua.sign & ub.sign, {(W-1){1'b0}}} :
                  ca == CLS_ZERO                   ? {ub.sign, b[W-2:0]} :
                                                     {ua.sign, a[W-2:0]};
    end

    int               sh;
    logic [2*SW-3:0]  wide;
    logic [SW-1:0]    lsig, bal, sum2_d;
    logic             v2_q, byp2_q, inv2_q, sign2_q;
    logic [W-1:0]     bval2_q;
    logic [EXP_W-1:0] exp2_q;
    logic [SW-1:0]    sum2_q;

    // Shifting through a double-width window keeps every lost bit for the sticky OR.
    always_comb begin
        sh     = (int'(d1_q) > SW - 1) ? SW - 1 : int'(d1_q);
        wide   = {sigs1_q, {GRS_W{1'b0}}, {(SW-1){1'b0}}} >> sh;
        bal    = {1'b0, wide[2*SW-3:SW], wide[SW-1] | (|wide[SW-2:0])};
        lsig   = {1'b0, sigl1_q, {GRS_W{1'b0}}};
        sum2_d = sub1_q ? lsig - bal : lsig + bal;
    end

    logic [LZ_W-1:0]  lz;
    logic             carry, inv_d, ovf_d;
    logic [SW-2:0]    nrm;
    logic [EXP_W+1:0] en, ef;
    logic [MAN_W:0]   fr;
    logic [W-1:0]     c_d;
    logic             ov_q, inv_q, ovf_q;
    logic [W-1:0]     c_q;

    bf_lzc #(.WIDTH(SW)) u_lzc (.vec_i(sum2_q), .cnt_o(lz));

    // nrm keeps the hidden bit on top; a zero hidden bit after normalising means exact cancellation.
    always_comb begin
        carry = sum2_q[SW-1];
        nrm   = carry ? {sum2_q[SW-1:2], |sum2_q[1:0]} : (SW-1)'(sum2_q << (lz - LZ_W'(1)));
        en    = carry ? {2'b00, exp2_q} + (EXP_W+2)'(1)
                      : {2'b00, exp2_q} + (EXP_W+2)'(1) - (EXP_W+2)'(lz);
        fr    = {1'b0, nrm[SW-3:GRS_W]} +
                (MAN_W+1)'(rne_inc(nrm[GRS_W], nrm[GRS_W-1], nrm[GRS_W-2], |nrm[GRS_W-3:0]));
        ef    = en + (EXP_W+2)'(fr[MAN_W]);
        c_d   = {sign2_q, ef[EXP_W-1:0], fr[MAN_W-1:0]};
        inv_d = 1'b0;
        ovf_d = 1'b0;
        if (byp2_q) begin
            c_d   = bval2_q;
            inv_d = inv2_q;
        end else if (!nrm[SW-2]) begin
            c_d = '0;
        end else if (en[EXP_W+1] || en == '0) begin
            c_d = {sign2_q, {(W-1){1'b0}}};
        end else if (ef >= EMAX) begin
            c_d   = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            ov_q  <= 1'b0;
            c_q   <= '0;
            inv_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (adv) begin
            v1_q  <= in_valid;
            v2_q  <= v1_q;
            ov_q  <= v2_q;
            c_q   <= c_d;
            inv_q <= inv_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            byp1_q  <= byp1_d;
            inv1_q  <= inv1_d;
            bval1_q <= bval1_d;
            sign1_q <= ul.sign;
            sub1_q  <= ul.sign ^ us.sign;
            exp1_q  <= ul.exp;
            d1_q    <= ul.exp - us.exp;
            sigl1_q <= ul.sig;
            sigs1_q <= us.sig;
            byp2_q  <= byp1_q;
            inv2_q  <= inv1_q;
            bval2_q <= bval1_q;
            sign2_q <= sign1_q;
            exp2_q  <= exp1_q;
            sum2_q  <= sum2_d;
        end
    end

    assign out_valid     = ov_q;
    assign c             = c_q;
    assign flag_invalid  = inv_q;
    assign flag_overflow = ovf_q;

`ifdef STICKY_FLAGS_EN
    logic sinv_q, sovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flag_clr) begin
            sinv_q <= 1'b0;
            sovf_q <= 1'b0;
        end else if (ov_q && out_ready) begin
            sinv_q <= sinv_q | inv_q;
            sovf_q <= sovf_q | ovf_q;
        end
    end

    assign sticky_invalid  = sinv_q;
    assign sticky_overflow = sovf_q;
`endif
endmodule

// File: tb/tb_bf_add_sub_pipe.sv
// tb_bf_add_sub_pipe: directed checks of bf_add_sub_pipe (bf16 defaults) with immediate assertions.
module tb_bf_add_sub_pipe;
    logic        clk, rst_n, in_valid, in_ready, cntl, out_valid, out_ready;
    logic        flag_invalid, flag_overflow;
    logic [15:0] a, b, c;
    int          n_assert = 0;
    int          n_fail   = 0;
`ifdef STICKY_FLAGS_EN
    logic        flag_clr, sticky_invalid, sticky_overflow;
`endif

    bf_add_sub_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cntl(cntl), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .flag_invalid(flag_invalid), .flag_overflow(flag_overflow)
`ifdef STICKY_FLAGS_EN
        , .flag_clr(flag_clr), .sticky_invalid(sticky_invalid), .sticky_overflow(sticky_overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] st_a   [8] = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0, 16'h40E0, 16'h4100};
    logic [15:0] st_exp [8] = '{16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0, 16'h40E0, 16'h4100, 16'h4110};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One isolated operation: transfer, then out_valid must rise exactly on the third cycle.
    task automatic run_op(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                          input logic xs, input logic [15:0] xc, input logic xinv, input logic xovf);
        a = xa; b = xb; cntl = xs; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 16'(in_ready), 16'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, ".early"}, 16'(out_valid), 16'd0);
        @(posedge clk); #1;
        check({tag, ".out_valid"}, 16'(out_valid), 16'd1);
        check({tag, ".c"}, c, xc);
        check({tag, ".inv"}, 16'(flag_invalid), 16'(xinv));
        check({tag, ".ovf"}, 16'(flag_overflow), 16'(xovf));
    endtask

    initial begin
        int si, ri;
        logic stalled, take;
        logic [15:0] held;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cntl = 1'b0;
`ifdef STICKY_FLAGS_EN
        flag_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst.out_valid", 16'(out_valid), 16'd0);
        check("rst.c", c, 16'h0000);
        check("rst.inv", 16'(flag_invalid), 16'd0);
        check("rst.ovf", 16'(flag_overflow), 16'd0);
        check("rst.in_ready", 16'(in_ready), 16'd1);
        rst_n = 1'b1;

        run_op("1p2",      16'h3F80, 16'h4000, 1'b0, 16'h4040, 1'b0, 1'b0);
        run_op("1m1",      16'h3F80, 16'h3F80, 1'b1, 16'h0000, 1'b0, 1'b0);
        run_op("infminf",  16'h7F80, 16'h7F80, 1'b1, 16'h7FC0, 1'b1, 1'b0);
        run_op("ovf",      16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, 1'b0, 1'b1);
        run_op("tie",      16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 1'b0, 1'b0);
        run_op("rne_up",   16'h3F81, 16'h3B80, 1'b0, 16'h3F82, 1'b0, 1'b0);
        run_op("subn",     16'h0001, 16'h3F80, 1'b0, 16'h3F80, 1'b0, 1'b0);
        run_op("nz_nz",    16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0);
        run_op("3m1",      16'h4040, 16'h3F80, 1'b1, 16'h4000, 1'b0, 1'b0);
        run_op("cancel",   16'h3F80, 16'h3F81, 1'b1, 16'hBC00, 1'b0, 1'b0);
        run_op("ninf",     16'h3F80, 16'hFF80, 1'b0, 16'hFF80, 1'b0, 1'b0);
        run_op("nan",      16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0, 1'b1, 1'b0);
        run_op("nz_pz",    16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain.out_valid", 16'(out_valid), 16'd0);
`ifdef STICKY_FLAGS_EN
        check("sticky.inv_set", 16'(sticky_invalid), 16'd1);
        check("sticky.ovf_set", 16'(sticky_overflow), 16'd1);
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        check("sticky.inv_clr", 16'(sticky_invalid), 16'd0);
        check("sticky.ovf_clr", 16'(sticky_overflow), 16'd0);
`endif

        si = 0; ri = 0; stalled = 1'b0; held = '0;
        cntl = 1'b0; b = 16'h3F80;
        for (int cyc = 0; cyc < 300 && ri < 8; cyc++) begin
            in_valid  = si < 8;
            a         = (si < 8) ? st_a[si] : 16'h0000;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (stalled && out_valid)
                check("stream.hold", c, held);
            if (out_valid && out_ready) begin
                check("stream.c", c, st_exp[ri]);
                ri++;
            end
            stalled = out_valid && !out_ready;
            held    = c;
            take    = in_valid && in_ready;
            @(posedge clk); #1;
            if (take) si++;
        end
        check("stream.count", 16'(ri), 16'd8);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("stream.no_extra", 16'(out_valid), 16'd0);

        a = 16'h3F80; b = 16'h4000; cntl = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'h4040;
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst.out_valid", 16'(out_valid), 16'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("midrst.no_stale", 16'(out_valid), 16'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
